// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master bridge and its address decoder.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   localparam logic [15:0] APB_BASE_HI = 16'h1000;
   localparam int          SLOT_W      = 4;
   localparam int          ADDR_W      = 32;
   localparam int          DATA_W      = 32;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational peripheral-window decode: 4 KiB slot per slave above APB_BASE_HI.
module apb_addr_decoder
   import apb_pkg::*;
#(
   parameter int NUM_SLV = 4
) (
   input  logic [ADDR_W-1:12]  addr,
   output logic [NUM_SLV-1:0]  sel,
   output logic                mapped
);

   logic [SLOT_W-1:0] slot;

   assign slot   = addr[15:12];
   // Extra MSB so NUM_SLV=16 still compares correctly.
   assign mapped = (addr[31:16] == APB_BASE_HI) &&
                   ({1'b0, slot} < (SLOT_W+1)'(NUM_SLV));

   for (genvar i = 0; i < NUM_SLV; i++) begin : g_sel
      assign sel[i] = mapped && (slot == SLOT_W'(i));
   end

endmodule

// File: rtl/apb_master_bridge.sv
// CPU single-cycle request to APB3 master: IDLE/SETUP/ACCESS FSM, slave select,
// response mux and wait-state timeout.
module apb_master_bridge
   import apb_pkg::*;
#(
   parameter int NUM_SLV = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                            PCLK,
   input  logic                            PRESET,
   input  logic                            transfer,
   input  logic                            write,
   input  logic [ADDR_W-1:0]               addr,
   input  logic [DATA_W-1:0]               wdata,
   output logic [DATA_W-1:0]               rdata,
   output logic                            ready,
   output logic                            error,
   output logic [ADDR_W-1:0]               PADDR,
   output logic                            PWRITE,
   output logic [DATA_W-1:0]               PWDATA,
   output logic                            PENABLE,
   output logic [NUM_SLV-1:0]              PSEL,
   input  logic [NUM_SLV-1:0][DATA_W-1:0]  PRDATA_S,
   input  logic [NUM_SLV-1:0]              PREADY_S
);

   localparam int CNT_W = $clog2(TIMEOUT);

   apb_state_e           state, state_nxt;
   logic [CNT_W-1:0]     cnt;
   logic [NUM_SLV-1:0]   sel;
   logic                 mapped;
   logic                 slv_rdy;
   logic [DATA_W-1:0]    prd_mux;
   logic                 done, done_err;

   apb_addr_decoder #(.NUM_SLV(NUM_SLV)) u_dec (
      .addr   (PADDR[ADDR_W-1:12]),
      .sel    (sel),
      .mapped (mapped)
   );

   assign PSEL    = (state == IDLE) ? '0 : sel;
   assign PENABLE = (state == ACCESS);

   // sel is one-hot (or zero), so AND-OR is a clean mux of the addressed slave.
   always_comb begin
      slv_rdy = |(PREADY_S & sel);
      prd_mux = '0;
      for (int i = 0; i < NUM_SLV; i++)
         if (sel[i]) prd_mux = prd_mux | PRDATA_S[i];
   end

   always_comb begin
      state_nxt = state;
      done      = 1'b0;
      done_err  = 1'b0;
      case (state)
         IDLE:   if (transfer) state_nxt = SETUP;
         SETUP:  state_nxt = ACCESS;
         ACCESS: begin
            if (!mapped) begin
               done     = 1'b1;
               done_err = 1'b1;
            end else if (slv_rdy) begin
               done     = 1'b1;
            end else if (cnt == CNT_W'(TIMEOUT-1)) begin
               done     = 1'b1;
               done_err = 1'b1;
            end
            if (done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state  <= IDLE;
         PADDR  <= '0;
         PWRITE <= 1'b0;
         PWDATA <= '0;
         cnt    <= '0;
         ready  <= 1'b0;
         error  <= 1'b0;
         rdata  <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && transfer) begin
            PADDR  <= addr;
            PWRITE <= write;
            PWDATA <= wdata;
         end
         if (state == SETUP)       cnt <= '0;
         else if (state == ACCESS) cnt <= cnt + CNT_W'(1);
         ready <= done;
         error <= done && done_err;
         rdata <= (done && !done_err && !PWRITE) ? prd_mux : '0;
      end
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge (NUM_SLV=4, TIMEOUT=16), hand-computed expectations.
module tb_apb_master_bridge;

   localparam int NUM_SLV = 4;
   localparam int TIMEOUT = 16;

   logic                           PCLK = 1'b0;
   logic                           PRESET;
   logic                           transfer, write;
   logic [31:0]                    addr, wdata;
   logic [31:0]                    rdata, PADDR, PWDATA;
   logic                           ready, error, PWRITE, PENABLE;
   logic [NUM_SLV-1:0]             PSEL;
   logic [NUM_SLV-1:0][31:0]       PRDATA_S;
   logic [NUM_SLV-1:0]             PREADY_S;

   int n_chk  = 0;
   int n_fail = 0;

   apb_master_bridge #(.NUM_SLV(NUM_SLV), .TIMEOUT(TIMEOUT)) dut (
      .PCLK     (PCLK),
      .PRESET   (PRESET),
      .transfer (transfer),
      .write    (write),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .ready    (ready),
      .error    (error),
      .PADDR    (PADDR),
      .PWRITE   (PWRITE),
      .PWDATA   (PWDATA),
      .PENABLE  (PENABLE),
      .PSEL     (PSEL),
      .PRDATA_S (PRDATA_S),
      .PREADY_S (PREADY_S)
   );

   always #5 PCLK = ~PCLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
   task automatic step();
      @(posedge PCLK);
      #1;
   endtask

   task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d);
      transfer = 1'b1;
      write    = w;
      addr     = a;
      wdata    = d;
   endtask

   task automatic idle_in();
      transfer = 1'b0;
      write    = 1'b0;
      addr     = 32'hDEAD_BEEF;
      wdata    = 32'hDEAD_BEEF;
   endtask

   initial begin
      int pen_cnt, rdy_cnt, psel_cnt;
      PRESET   = 1'b1;
      idle_in();
      PRDATA_S = '0;
      PREADY_S = '0;
      step();
      step();
      chk("rst_psel",    32'(PSEL),    32'h0);
      chk("rst_penable", 32'(PENABLE), 32'h0);
      chk("rst_paddr",   PADDR,        32'h0);
      chk("rst_pwdata",  PWDATA,       32'h0);
      chk("rst_pwrite",  32'(PWRITE),  32'h0);
      chk("rst_ready",   32'(ready),   32'h0);
      chk("rst_error",   32'(error),   32'h0);
      chk("rst_rdata",   rdata,        32'h0);
      PRESET = 1'b0;
      step();

      // Write, slave 2 with one wait state: ready at cycle 4.
      req(1'b1, 32'h1000_2000, 32'h0000_00FF);                 // cycle 0
      step(); idle_in();                                      // cycle 1 SETUP
      chk("wr_c1_psel",    32'(PSEL),    32'h4);
      chk("wr_c1_penable", 32'(PENABLE), 32'h0);
      chk("wr_c1_paddr",   PADDR,        32'h1000_2000);
      chk("wr_c1_pwdata",  PWDATA,       32'h0000_00FF);
      chk("wr_c1_pwrite",  32'(PWRITE),  32'h1);
      step();                                                 // cycle 2 ACCESS
      chk("wr_c2_psel",    32'(PSEL),    32'h4);
      chk("wr_c2_penable", 32'(PENABLE), 32'h1);
      step(); PREADY_S = 4'b0100;                             // cycle 3 ACCESS
      chk("wr_c3_psel",    32'(PSEL),    32'h4);
      chk("wr_c3_penable", 32'(PENABLE), 32'h1);
      chk("wr_c3_ready",   32'(ready),   32'h0);
      step(); PREADY_S = '0;                                  // cycle 4
      chk("wr_c4_ready",   32'(ready),   32'h1);
      chk("wr_c4_error",   32'(error),   32'h0);
      chk("wr_c4_psel",    32'(PSEL),    32'h0);
      chk("wr_c4_penable", 32'(PENABLE), 32'h0);
      chk("wr_c4_paddr_hold", PADDR,     32'h1000_2000);
      step();
      chk("wr_c5_ready",   32'(ready),   32'h0);

      // Read slot 2 zero-wait; slot 1 chatters and must be ignored.
      PRDATA_S[1] = 32'h5555_5555;
      PRDATA_S[2] = 32'h0000_00A5;
      PREADY_S    = 4'b0010;
      req(1'b0, 32'h1000_2004, 32'h1234_5678);                 // cycle 0
      step(); idle_in();                                      // cycle 1
      step(); PREADY_S = 4'b0110;                             // cycle 2 ACCESS
      step(); PREADY_S = '0;                                  // cycle 3
      chk("rd_ready", 32'(ready), 32'h1);
      chk("rd_error", 32'(error), 32'h0);
      chk("rd_rdata", rdata,      32'h0000_00A5);
      step();
      chk("rd_ready_clr", 32'(ready), 32'h0);
      chk("rd_rdata_clr", rdata,      32'h0);

      // Unmapped: outside window, and slot >= NUM_SLV.
      PREADY_S = 4'b1111;
      for (int k = 0; k < 2; k++) begin
         psel_cnt = 0;
         req(1'b0, (k == 0) ? 32'h2000_0000 : 32'h1000_7000, 32'h0);
         step(); idle_in();
         psel_cnt += (PSEL != 0) ? 1 : 0;
         step();
         psel_cnt += (PSEL != 0) ? 1 : 0;
         chk($sformatf("unm%0d_c2_ready", k), 32'(ready), 32'h0);
         step();
         chk($sformatf("unm%0d_psel_cnt", k), 32'(psel_cnt), 32'h0);
         chk($sformatf("unm%0d_ready", k),    32'(ready),    32'h1);
         chk($sformatf("unm%0d_error", k),    32'(error),    32'h1);
         chk($sformatf("unm%0d_rdata", k),    rdata,         32'h0);
         step();
      end

      // Highest mapped slot (3) is decoded.
      PRDATA_S[3] = 32'hCAFE_0003;
      PREADY_S    = 4'b1000;
      req(1'b0, 32'h1000_3010, 32'h0);
      step(); idle_in();
      chk("s3_psel", 32'(PSEL), 32'h8);
      step();
      step();
      chk("s3_ready", 32'(ready), 32'h1);
      chk("s3_error", 32'(error), 32'h0);
      chk("s3_rdata", rdata,      32'hCAFE_0003);
      PREADY_S = '0;
      step();

      // Timeout: slot 1 never ready, unselected slot 0 ready is ignored.
      PREADY_S = 4'b0001;
      pen_cnt  = 0;
      rdy_cnt  = 0;
      req(1'b0, 32'h1000_1000, 32'h0);                         // cycle 0
      for (int c = 1; c <= 1 + TIMEOUT; c++) begin             // cycles 1..17
         step(); idle_in();
         pen_cnt += PENABLE ? 1 : 0;
         rdy_cnt += ready ? 1 : 0;
      end
      chk("to_penable_cycles", 32'(pen_cnt), 32'(TIMEOUT));
      chk("to_early_ready",    32'(rdy_cnt), 32'h0);
      step();                                                 // cycle 18
      chk("to_ready",   32'(ready),   32'h1);
      chk("to_error",   32'(error),   32'h1);
      chk("to_rdata",   rdata,        32'h0);
      chk("to_psel",    32'(PSEL),    32'h0);
      chk("to_penable", 32'(PENABLE), 32'h0);
      PREADY_S = '0;
      step();
      chk("to_ready_clr", 32'(ready), 32'h0);

      // Back-to-back with residual PREADY through IDLE/SETUP.
      PRDATA_S[2] = 32'h0000_0011;
      req(1'b0, 32'h1000_2000, 32'h0);                         // cycle 0
      step(); idle_in();                                      // 1 SETUP
      step(); PREADY_S = 4'b0100;                             // 2 ACCESS
      step();                                                 // 3 ready, IDLE
      chk("b2b_first_ready", 32'(ready), 32'h1);
      chk("b2b_first_rdata", rdata,      32'h0000_0011);
      req(1'b1, 32'h1000_2008, 32'hA5A5_0000);
      step(); idle_in();                                      // 4 SETUP, PREADY still high
      chk("b2b_setup_psel",  32'(PSEL),  32'h4);
      chk("b2b_setup_ready", 32'(ready), 32'h0);
      chk("b2b_paddr",       PADDR,      32'h1000_2008);
      chk("b2b_pwdata",      PWDATA,     32'hA5A5_0000);
      PREADY_S = '0;
      step();                                                 // 5 ACCESS, no PREADY
      chk("b2b_c5_penable", 32'(PENABLE), 32'h1);
      chk("b2b_c5_ready",   32'(ready),   32'h0);
      step();                                                 // 6 ACCESS
      chk("b2b_no_early_ready", 32'(ready), 32'h0);
      PREADY_S = 4'b0100;
      step(); PREADY_S = '0;                                  // 7
      chk("b2b_second_ready", 32'(ready), 32'h1);
      chk("b2b_second_error", 32'(error), 32'h0);
      chk("b2b_second_rdata", rdata,      32'h0);
      step();

      // Reset during ACCESS drops the transfer.
      PRDATA_S[1] = 32'h0000_0077;
      req(1'b0, 32'h1000_1000, 32'h0);
      step(); idle_in();
      step();
      chk("rst_acc_penable_before", 32'(PENABLE), 32'h1);
      PREADY_S = 4'b0010;
      PRESET   = 1'b1;
      step();
      chk("rst_acc_psel",    32'(PSEL),    32'h0);
      chk("rst_acc_penable", 32'(PENABLE), 32'h0);
      chk("rst_acc_ready",   32'(ready),   32'h0);
      chk("rst_acc_paddr",   PADDR,        32'h0);
      PRESET   = 1'b0;
      PREADY_S = '0;
      step();
      chk("rst_acc_no_pulse", 32'(ready), 32'h0);
      req(1'b0, 32'h1000_1004, 32'h0);
      step(); idle_in();
      chk("post_rst_psel", 32'(PSEL), 32'h2);
      step(); PREADY_S = 4'b0010;
      step(); PREADY_S = '0;
      chk("post_rst_ready", 32'(ready), 32'h1);
      chk("post_rst_error", 32'(error), 32'h0);
      chk("post_rst_rdata", rdata,      32'h0000_0077);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Bridges the CPU core's single-cycle data-bus request into APB3 transfers toward the peripheral slaves (GPIO, GPO, UART, timer slots). It decodes the peripheral address window, drives one PSEL per slot and muxes the slave responses back. It also terminates stalled or unmapped accesses with an error. It sits directly upstream of every APB slave: their PADDR/PWRITE/PSEL/PENABLE/PWDATA come from here, and their PRDATA/PREADY return here.

## Interface
- NUM_SLV, 4, number of APB slave slots (1..16).
- TIMEOUT, 16, ACCESS cycles without PREADY before the bridge aborts with error (≥2).
- PCLK  in  1  APB/system clock; all logic on rising edge.
- PRESET  in  1  reset, synchronous, active-high.
- transfer  in  1  single-cycle request pulse from CPU; sampled only in IDLE.
- write  in  1  1 = write, 0 = read; qualified by transfer.
- addr  in  32  byte address; qualified by transfer.
- wdata  in  32  write data; qualified by transfer.
- rdata  out  32  read data; valid while ready=1.
- ready  out  1  one-cycle completion pulse.
- error  out  1  valid with ready; 1 = unmapped or timeout.
- PADDR  out  32  latched address.
- PWRITE  out  1  latched direction.
- PWDATA  out  32  latched write data.
- PENABLE  out  1  APB enable.
- PSEL  out  NUM_SLV  one-hot slave select.
- PRDATA_S  in  NUM_SLV×32  per-slave read data.
- PREADY_S  in  NUM_SLV  per-slave ready.

## Operation
- Decode:
  - Mapped iff addr[31:16] = 16'h1000 and addr[15:12] < NUM_SLV.
  - Slot = addr[15:12].
  - Decode is evaluated on the latched address.
- FSM states are IDLE, SETUP and ACCESS.
- IDLE:
  - transfer=1 latches addr/write/wdata into PADDR/PWRITE/PWDATA and the slot/mapped flags, then goes to SETUP.
  - transfer=0 stays in IDLE.
- SETUP:
  - PSEL[slot]=1 if mapped, else all PSEL=0. PENABLE=0.
  - Always goes to ACCESS.
- ACCESS:
  - PSEL is held and PENABLE=1.
  - Unmapped: completes in the first ACCESS cycle with error=1.
  - Mapped: completes when PREADY_S[slot]=1, or with error=1 when the wait counter reaches TIMEOUT-1 without PREADY.
  - Completion returns to IDLE.
- Completion, registered:
  - Next cycle ready=1.
  - rdata = PRDATA_S[slot] for a successful read, else 0.
  - error as above.
- Wait counter:
  - Cleared on entering ACCESS; increments each ACCESS cycle.
  - Width $clog2(TIMEOUT).
- PREADY_S is sampled only in ACCESS; a slave's residual PREADY during IDLE/SETUP is ignored.
- PSEL bits of non-selected slots are always 0. Unselected PREADY_S/PRDATA_S are ignored.
- transfer outside IDLE is ignored; the requester must wait for ready.
- transfer in the same cycle as ready is legal (bridge is in IDLE) and is accepted.
- PADDR/PWRITE/PWDATA hold their last value in IDLE.

## Timing
- Reset values:
  - State IDLE.
  - PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0.
  - rdata=0, ready=0, error=0, counter=0.
- Reset asserted in any state returns all of the above at the next edge. An in-flight transfer is dropped with no ready pulse.
- Zero-wait slave (PREADY in first ACCESS cycle), transfer at cycle 0:
  - SETUP at 1.
  - ACCESS at 2.
  - ready at 3.
- Slave with registered PREADY (one wait state):
  - ACCESS at 2–3.
  - ready at 4.
- Minimum request-to-request spacing is 3 cycles (back-to-back: transfer in ready cycle).
- Timeout:
  - ACCESS occupies TIMEOUT cycles.
  - ready/error=1 at cycle 2+TIMEOUT.
- Unmapped: ready/error=1 at cycle 3, no PSEL ever asserted.
- ready, error and rdata are single-cycle: cleared the cycle after assertion unless a new completion occurs.

## Structure
- apb_pkg holds:
  - state enum (IDLE, SETUP, ACCESS).
  - APB_BASE_HI = 16'h1000.
  - SLOT_W = 4.
  - shared width localparams.
- Sub-module apb_addr_decoder is combinational and maps the latched address to a one-hot select plus the mapped flag. It is reusable by a future second bridge.
- FSM, latches, counter and response mux live in apb_master_bridge.

## Test plan
- Write GPIO DDR: transfer write addr=0x1000_2000 wdata=0xFF, slave 2 PREADY one wait → PSEL=4'b0100 cycles 1–3, PENABLE cycles 2–3, ready=1 error=0 at cycle 4.
- Read: slave 2 returns PRDATA=0x0000_00A5 with PREADY → rdata=0x0000_00A5, ready=1, error=0 one cycle after PREADY.
- Unmapped addr=0x2000_0000 and addr=0x1000_7000 (NUM_SLV=4) → PSEL stays 0, ready=1 error=1 rdata=0 at cycle 3.
- Slave never asserts PREADY, TIMEOUT=16 → PENABLE high 16 cycles, ready=1 error=1 at cycle 18, FSM back in IDLE.
- Back-to-back: second transfer pulsed in ready cycle, residual PREADY high during next SETUP → second transfer completes only after a fresh PREADY in ACCESS; no early ready.
- PRESET asserted in ACCESS → next edge PSEL=0, PENABLE=0, ready=0; no completion pulse; new transfer after reset completes normally.
